decimal_entry_encoder: RTL and testbench

//  Decimal-to-binary entry block for the options menu; the inverse of GS_DECIMALIZER.
//  - Collects BCD digit keystrokes for one option field (pin_colors, guesses, PIX_W, ...).
//  - On commit, converts the digits to binary by iterative Horner (acc*10+d) and clamps the result to [MIN_VAL, MAX_VAL].
//  - The game state machine writes value into GS.options.

---
 rtl/decimal_entry_encoder_pkg.sv | 39 +++
 rtl/decimal_entry_encoder_dec_mac10.sv | 18 +
 rtl/decimal_entry_encoder.sv | 169 ++++++++++++++++
 tb/tb_decimal_entry_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_entry_encoder_pkg.sv
// Shared types and option-field constants for the decimal entry path of the options menu.
// Holds the decimalized game-state view and the per-field clamp ranges.
package decimal_entry_encoder_pkg;

    typedef logic [3:0] t_bcd_digit;

    localparam t_bcd_digit BCD_MAX = 4'd9;

    localparam int GS_DECIM_PIN_COLORS_LEN = 2;
    localparam int GS_DECIM_PINS_COUNT_LEN = 1;
    localparam int GS_DECIM_GUESSES_LEN    = 2;
    localparam int GS_DECIM_PIX_W_LEN      = 3;

    localparam int max_pin_colors = 10;
    localparam int max_pins_count = 8;
    localparam int max_guesses    = 20;

    localparam int PIN_COLORS_MIN = 2;
    localparam int PIN_COLORS_MAX = max_pin_colors;
    localparam int PINS_COUNT_MIN = 1;
    localparam int PINS_COUNT_MAX = max_pins_count;
    localparam int GUESSES_MIN    = 1;
    localparam int GUESSES_MAX    = max_guesses;

    typedef struct packed {
        t_bcd_digit [GS_DECIM_PIN_COLORS_LEN-1:0] pin_colors;
        t_bcd_digit [GS_DECIM_PINS_COUNT_LEN-1:0] pins_count;
        t_bcd_digit [GS_DECIM_GUESSES_LEN-1:0]    guesses;
        t_bcd_digit [GS_DECIM_PIX_W_LEN-1:0]      pix_w;
    } st_GS_DECIMALIZED;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CONVERT,
        ST_DONE
    } entry_state_e;

endpackage

// File: rtl/decimal_entry_encoder_dec_mac10.sv
// Combinational Horner step: result = acc*10 + digit, saturating at all-ones.
module dec_mac10
    import decimal_entry_encoder_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic [AW-1:0] acc,
    input  t_bcd_digit    digit,
    output logic [AW-1:0] result
);

    // Four extra bits always hold acc*10+9 without overflow, so any set top bit means saturate.
    logic [AW+3:0] wide;

    assign wide   = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{AW{1'b0}}, digit};
    assign result = (wide[AW+3:AW] != 4'b0000) ? '1 : wide[AW-1:0];

endmodule

// File: rtl/decimal_entry_encoder.sv
// Decimal keystroke entry for one option field: buffers BCD digits, converts them to binary
// on commit and clamps to [MIN_VAL, MAX_VAL]. Define DECIMAL_ENTRY_WRAP_EN to let a full buffer roll over.
module decimal_entry_encoder
    import decimal_entry_encoder_pkg::*;
#(
    parameter int W       = 8,
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 1,
    parameter int MAX_VAL = 99
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [W-1:0]                init_value,
    input  logic                        digit_valid,
    input  logic [3:0]                  digit,
    input  logic                        backspace,
    input  logic                        commit,
    input  logic                        cancel,
    output logic                        busy,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic [DIGITS*4-1:0]         digits_out,
    output logic                        value_valid,
    output logic [W-1:0]                value,
    output logic                        clamped
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int AW = W + 4;
    localparam int BW = DIGITS * 4;
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [AW-1:0] ACC_MIN  = AW'(MIN_VAL);
    localparam logic [AW-1:0] ACC_MAX  = AW'(MAX_VAL);

    entry_state_e  state_q, state_d;
    logic [BW-1:0] dig_q;
    logic [BW-1:0] dig_shl;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] mac_res;
    logic [W-1:0]  init_q;
    logic [W-1:0]  value_q;
    logic          clamped_q;
    logic [W-1:0]  clamp_val;
    logic          clamp_hit;
    logic          key_ok;
    t_bcd_digit    cur_digit;

    assign dig_shl = (dig_q << 4) | BW'(digit);
    assign key_ok  = digit_valid && (digit <= BCD_MAX);

    // Digits are consumed most-significant first: idx_q counts down from digit_count-1.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == CW'(i)) cur_digit = dig_q[i*4 +: 4];
        end
    end

    dec_mac10 #(.AW(AW)) u_mac (
        .acc    (acc_q),
        .digit  (cur_digit),
        .result (mac_res)
    );

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        clamp_val = mac_res[W-1:0];
        clamp_hit = 1'b0;
        if (mac_res > ACC_MAX) begin
            clamp_val = W'(MAX_VAL);
            clamp_hit = 1'b1;
        end else if (mac_res < ACC_MIN) begin
            clamp_val = W'(MIN_VAL);
            clamp_hit = 1'b1;
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ENTRY;
            ST_ENTRY: begin
                if (cancel)      state_d = ST_IDLE;
                else if (commit) state_d = (cnt_q == '0) ? ST_DONE : ST_CONVERT;
            end
            ST_CONVERT: if (idx_q == '0) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: the digit buffer is reset explicitly because it drives digits_out directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            init_q    <= '0;
            value_q   <= '0;
            clamped_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        init_q <= init_value;
                        dig_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                ST_ENTRY: begin
                    if (cancel) begin
                        dig_q <= '0;
                        cnt_q <= '0;
                    end else if (commit) begin
                        if (cnt_q == '0) begin
                            value_q   <= init_q;
                            clamped_q <= 1'b0;
                        end else begin
                            idx_q <= cnt_q - 1'b1;
                            acc_q <= '0;
                        end
                    end else if (backspace) begin
                        if (cnt_q != '0) begin
                            dig_q <= dig_q >> 4;
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end else if (key_ok) begin
                        if (cnt_q != CNT_FULL) begin
                            dig_q <= dig_shl;
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
`ifdef DECIMAL_ENTRY_WRAP_EN
                            dig_q <= dig_shl;
`endif
                        end
                    end
                end
                ST_CONVERT: begin
                    acc_q <= mac_res;
                    idx_q <= idx_q - 1'b1;
                    if (idx_q == '0) begin
                        value_q   <= clamp_val;
                        clamped_q <= clamp_hit;
                        dig_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q == ST_ENTRY) || (state_q == ST_CONVERT);
    assign value_valid = (state_q == ST_DONE);
    assign digit_count = cnt_q;
    assign digits_out  = dig_q;
    assign value       = value_q;
    assign clamped     = clamped_q;

endmodule

// File: tb/tb_decimal_entry_encoder.sv
// Bench for decimal_entry_encoder: two instances (default clamp range and [2,21]) share stimulus
// and are compared every cycle against a queue-based model; directed cases pin literal results.
module tb_decimal_entry_encoder;

`ifdef DECIMAL_ENTRY_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int DIGITS = 2;
    localparam int SAT    = 4095;
    localparam int PH_IDLE = 0, PH_ENTRY = 1, PH_CONV = 2, PH_DONE = 3;

    int lo [2] = '{1, 2};
    int hi [2] = '{99, 21};

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       start       = 1'b0;
    logic [7:0] init_value  = 8'd0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit       = 4'd0;
    logic       backspace   = 1'b0;
    logic       commit      = 1'b0;
    logic       cancel      = 1'b0;

    logic       busy_o [2];
    logic [1:0] cnt_o  [2];
    logic [7:0] dout_o [2];
    logic       vv_o   [2];
    logic [7:0] val_o  [2];
    logic       clp_o  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decimal_entry_encoder dut (
        .clk(clk), .rst(rst), .start(start), .init_value(init_value),
        .digit_valid(digit_valid), .digit(digit), .backspace(backspace),
        .commit(commit), .cancel(cancel), .busy(busy_o[0]), .digit_count(cnt_o[0]),
        .digits_out(dout_o[0]), .value_valid(vv_o[0]), .value(val_o[0]), .clamped(clp_o[0])
    );

    decimal_entry_encoder #(.W(8), .DIGITS(2), .MIN_VAL(2), .MAX_VAL(21)) dut_c (
        .clk(clk), .rst(rst), .start(start), .init_value(init_value),
        .digit_valid(digit_valid), .digit(digit), .backspace(backspace),
        .commit(commit), .cancel(cancel), .busy(busy_o[1]), .digit_count(cnt_o[1]),
        .digits_out(dout_o[1]), .value_valid(vv_o[1]), .value(val_o[1]), .clamped(clp_o[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: digits as a queue (oldest = most significant), conversion as plain arithmetic.
    int m_phase = PH_IDLE;
    int m_q[$];
    int m_left = 0;
    int m_init = 0;
    int m_num  = 0;
    int m_val [2] = '{0, 0};
    int m_clp [2] = '{0, 0};

    function automatic int packed_digits();
        int r = 0;
        for (int i = 0; i < m_q.size(); i++) r += m_q[m_q.size() - 1 - i] << (4 * i);
        return r;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_phase = PH_IDLE;
            m_q.delete();
            m_left  = 0;
            m_init  = 0;
            m_val   = '{0, 0};
            m_clp   = '{0, 0};
        end else begin
            case (m_phase)
                PH_IDLE: if (start) begin
                    m_phase = PH_ENTRY;
                    m_init  = int'(init_value);
                end
                PH_ENTRY: begin
                    if (cancel) begin
                        m_q.delete();
                        m_phase = PH_IDLE;
                    end else if (commit) begin
                        if (m_q.size() == 0) begin
                            m_val   = '{m_init, m_init};
                            m_clp   = '{0, 0};
                            m_phase = PH_DONE;
                        end else begin
                            m_num = 0;
                            foreach (m_q[i]) begin
                                m_num = m_num * 10 + m_q[i];
                                if (m_num > SAT) m_num = SAT;
                            end
                            m_left  = m_q.size();
                            m_phase = PH_CONV;
                        end
                    end else if (backspace) begin
                        if (m_q.size() > 0) void'(m_q.pop_back());
                    end else if (digit_valid && digit <= 4'd9) begin
                        if (m_q.size() < DIGITS) begin
                            m_q.push_back(int'(digit));
                        end else if (WRAP) begin
                            void'(m_q.pop_front());
                            m_q.push_back(int'(digit));
                        end
                    end
                end
                PH_CONV: begin
                    m_left--;
                    if (m_left == 0) begin
                        for (int k = 0; k < 2; k++) begin
                            if (m_num > hi[k])      begin m_val[k] = hi[k]; m_clp[k] = 1; end
                            else if (m_num < lo[k]) begin m_val[k] = lo[k]; m_clp[k] = 1; end
                            else                    begin m_val[k] = m_num; m_clp[k] = 0; end
                        end
                        m_q.delete();
                        m_phase = PH_DONE;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busy[%0d]", k), 64'(busy_o[k]),
                      64'(m_phase == PH_ENTRY || m_phase == PH_CONV));
                check($sformatf("digit_count[%0d]", k), 64'(cnt_o[k]), 64'(m_q.size()));
                check($sformatf("digits_out[%0d]", k), 64'(dout_o[k]), 64'(packed_digits()));
                check($sformatf("value_valid[%0d]", k), 64'(vv_o[k]), 64'(m_phase == PH_DONE));
                check($sformatf("value[%0d]", k), 64'(val_o[k]), 64'(m_val[k]));
                check($sformatf("clamped[%0d]", k), 64'(clp_o[k]), 64'(m_clp[k]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start(input int init);
        init_value = 8'(init);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic key(input int d);
        digit = 4'(d);
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic bksp();
        backspace = 1'b1;
        step();
        backspace = 1'b0;
    endtask

    task automatic commit_wait(input string name, input int lat_exp,
                               input int v0, input int c0, input int v1, input int c1);
        int lat;
        commit = 1'b1;
        step();
        commit = 1'b0;
        lat = 1;
        while (!vv_o[0] && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(lat_exp));
        check({name, "_value"}, 64'(val_o[0]), 64'(v0));
        check({name, "_clamped"}, 64'(clp_o[0]), 64'(c0));
        check({name, "_value_c"}, 64'(val_o[1]), 64'(v1));
        check({name, "_clamped_c"}, 64'(clp_o[1]), 64'(c1));
    endtask

    initial begin
        repeat (3) step();
        check("reset_busy", 64'(busy_o[0]), 64'd0);
        check("reset_value", 64'(val_o[0]), 64'd0);
        check("reset_digits", 64'(dout_o[0]), 64'd0);
        rst = 1'b0;
        step();

        do_start(12); key(4); key(7);
        check("digits_47", 64'(dout_o[0]), 64'h47);
        commit_wait("t1_47", 3, 47, 0, 21, 1);
        step();

        do_start(12);
        commit_wait("t2_empty", 1, 12, 0, 12, 0);
        step();

        do_start(12); key(9); key(9);
        commit_wait("t3_99", 3, 99, 0, 21, 1);
        step();
        do_start(12); key(0);
        commit_wait("t3_0", 2, 1, 1, 2, 1);
        step();

        do_start(5); key(3); key(8); key(5);
        check("t4_digits", 64'(dout_o[0]), WRAP ? 64'h85 : 64'h38);
        check("t4_count", 64'(cnt_o[0]), 64'd2);
        commit_wait("t4_commit", 3, WRAP ? 85 : 38, 0, 21, 1);
        step();

        do_start(5); key(6); key(2); bksp(); key(1); key(12);
        check("t5_digits", 64'(dout_o[0]), 64'h61);
        commit_wait("t5_61", 3, 61, 0, 21, 1);
        step();
        do_start(5); key(4); bksp(); bksp(); bksp();
        check("t5_underflow", 64'(cnt_o[0]), 64'd0);
        check("t5_busy", 64'(busy_o[0]), 64'd1);
        cancel = 1'b1; step(); cancel = 1'b0;

        do_start(5); key(5); key(5);
        commit = 1'b1; step(); commit = 1'b0;
        check("t6_converting", 64'(busy_o[0]), 64'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_rst_busy", 64'(busy_o[0]), 64'd0);
        check("t6_rst_value", 64'(val_o[0]), 64'd0);
        check("t6_rst_count", 64'(cnt_o[0]), 64'd0);
        repeat (3) begin
            check("t6_no_pulse", 64'(vv_o[0]), 64'd0);
            step();
        end

        do_start(5); key(7);
        commit_wait("t6_seed", 2, 7, 0, 7, 0);
        step();
        do_start(5); key(3);
        cancel = 1'b1; commit = 1'b1; step(); cancel = 1'b0; commit = 1'b0;
        check("t6_cancel_busy", 64'(busy_o[0]), 64'd0);
        check("t6_cancel_value", 64'(val_o[0]), 64'd7);
        repeat (3) begin
            check("t6_cancel_no_pulse", 64'(vv_o[0]), 64'd0);
            step();
        end

        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 5) == 0);
            init_value  = 8'($urandom_range(0, 255));
            digit_valid = ($urandom_range(0, 1) == 0);
            digit       = 4'($urandom_range(0, 15));
            backspace   = ($urandom_range(0, 9) == 0);
            commit      = ($urandom_range(0, 9) == 0);
            cancel      = ($urandom_range(0, 29) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0; digit_valid = 1'b0;
        backspace = 1'b0; commit = 1'b0; cancel = 1'b0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
